inversemapping_table_access_ctrl: RTL and testbench

- Owns the single port of the inverse-mapping (regroup) table RAM: 256 entries × 62 bits, entry = {flowid[61:48], dmac[47:0]}, all-zero entry = invalid.
- Arbitrates between the sequential-search lookup engine and the management configuration port.
- Zero-fills the table after reset and on a clear command.
- Sits between the frame inverse-mapping lookup logic, the host-side configuration bus and the table RAM.

---
 rtl/inversemapping_table_access_ctrl_pkg.sv | 33 +++
 rtl/inversemapping_table_access_ctrl_if.sv | 48 ++++
 rtl/inversemapping_table_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_inversemapping_table_access_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/inversemapping_table_access_ctrl_pkg.sv
// rtl/inversemapping_table_access_ctrl_pkg.sv - regroup table geometry, entry fields and FSM states
package inversemapping_table_access_ctrl_pkg;

  localparam int ADDR_WIDTH  = 8;
  localparam int DATA_WIDTH  = 62;
  localparam int TABLE_DEPTH = 256;
  localparam int RD_LATENCY  = 2;

  localparam int FLOWID_MSB = 61;
  localparam int FLOWID_LSB = 48;
  localparam int DMAC_MSB   = 47;

  // One extra bit so the init counter can reach TABLE_DEPTH without wrapping.
  localparam int INIT_CNT_W = $clog2(TABLE_DEPTH) + 1;
  localparam int WAIT_CNT_W = $clog2(RD_LATENCY + 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] entry_t;

  typedef enum logic [2:0] {
    INIT_S   = 3'd0,
    IDLE_S   = 3'd1,
    LOOK_S   = 3'd2,
    CFG_WR_S = 3'd3,
    CFG_RD_S = 3'd4
  } state_t;

  function automatic entry_t make_entry(input logic [FLOWID_MSB-FLOWID_LSB:0] flowid,
                                        input logic [DMAC_MSB:0] dmac);
    return {flowid, dmac};
  endfunction

endpackage

// File: rtl/inversemapping_table_access_ctrl_if.sv
// rtl/inversemapping_table_access_ctrl_if.sv - lookup, config, clear and table RAM signals
interface inversemapping_table_access_ctrl_if;
  import inversemapping_table_access_ctrl_pkg::*;

  logic   i_lookup_rd;
  addr_t  iv_lookup_raddr;
  entry_t ov_lookup_rdata;
  logic   o_lookup_ready;

  logic   i_cfg_wr;
  logic   i_cfg_rd;
  addr_t  iv_cfg_addr;
  entry_t iv_cfg_wdata;
  logic   o_cfg_ack;
  entry_t ov_cfg_rdata;

  logic   i_table_clear;
  logic   o_init_done;

  logic   o_ram_wr;
  logic   o_ram_rd;
  addr_t  ov_ram_addr;
  entry_t ov_ram_wdata;
  entry_t iv_ram_rdata;

  modport slave (
    input  i_lookup_rd, iv_lookup_raddr,
    output ov_lookup_rdata, o_lookup_ready,
    input  i_cfg_wr, i_cfg_rd, iv_cfg_addr, iv_cfg_wdata,
    output o_cfg_ack, ov_cfg_rdata,
    input  i_table_clear,
    output o_init_done,
    output o_ram_wr, o_ram_rd, ov_ram_addr, ov_ram_wdata,
    input  iv_ram_rdata
  );

  modport master (
    output i_lookup_rd, iv_lookup_raddr,
    input  ov_lookup_rdata, o_lookup_ready,
    output i_cfg_wr, i_cfg_rd, iv_cfg_addr, iv_cfg_wdata,
    input  o_cfg_ack, ov_cfg_rdata,
    output i_table_clear,
    input  o_init_done,
    input  o_ram_wr, o_ram_rd, ov_ram_addr, ov_ram_wdata,
    output iv_ram_rdata
  );

endinterface

// File: rtl/inversemapping_table_access_ctrl.sv
// rtl/inversemapping_table_access_ctrl.sv - single-port regroup table arbiter with zero-fill
module inversemapping_table_access_ctrl
  import inversemapping_table_access_ctrl_pkg::*;
(
  input logic                               i_clk,
  input logic                               i_rst,
  inversemapping_table_access_ctrl_if.slave bus
);

  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(TABLE_DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(RD_LATENCY);

  state_t                state_q, state_d;
  logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  clr_pend_q, clr_pend_d;
  logic                  init_done_q, init_done_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  entry_t                cfg_rdata_q, cfg_rdata_d;
  logic                  ram_wr_q, ram_wr_d;
  logic                  ram_rd_q, ram_rd_d;
  addr_t                 ram_addr_q, ram_addr_d;
  entry_t                ram_wdata_q, ram_wdata_d;

  logic clear_req;
  logic cfg_req;
  logic lookup_grant;

  assign clear_req = clr_pend_q | bus.i_table_clear;
  // The requester still holds its level during the ack cycle; that must not start a second access.
  assign cfg_req = (bus.i_cfg_wr | bus.i_cfg_rd) & ~ack_q;
  assign lookup_grant = (state_q == LOOK_S) ||
                        ((state_q == IDLE_S) && !clear_req && bus.i_lookup_rd);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= INIT_S;
      init_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      clr_pend_q  <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      cfg_rdata_q <= '0;
      ram_wr_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      clr_pend_q  <= clr_pend_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      cfg_rdata_q <= cfg_rdata_d;
      ram_wr_q    <= ram_wr_d;
      ram_rd_q    <= ram_rd_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    clr_pend_d  = clr_pend_q;
    init_done_d = init_done_q;
    ack_d       = 1'b0;
    cfg_rdata_d = cfg_rdata_q;
    ram_wr_d    = 1'b0;
    ram_rd_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    if (bus.i_table_clear && (state_q != INIT_S) && (state_q != IDLE_S)) begin
      clr_pend_d = 1'b1;
    end

    case (state_q)
      INIT_S: begin
        if (bus.i_table_clear) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == INIT_LAST) begin
          state_d     = IDLE_S;
          init_done_d = 1'b1;
        end else begin
          ram_wr_d    = 1'b1;
          ram_addr_d  = init_cnt_q[ADDR_WIDTH-1:0];
          ram_wdata_d = '0;
          init_cnt_d  = init_cnt_q + INIT_CNT_W'(1);
        end
      end

      IDLE_S: begin
        if (clear_req) begin
          state_d     = INIT_S;
          init_cnt_d  = '0;
          init_done_d = 1'b0;
          clr_pend_d  = 1'b0;
        end else if (bus.i_lookup_rd) begin
          state_d    = LOOK_S;
          wait_cnt_d = '0;
        end else if (cfg_req && bus.i_cfg_wr) begin
          state_d     = CFG_WR_S;
          ram_wr_d    = 1'b1;
          ram_addr_d  = bus.iv_cfg_addr;
          ram_wdata_d = bus.iv_cfg_wdata;
        end else if (cfg_req) begin
          state_d    = CFG_RD_S;
          ram_rd_d   = 1'b1;
          ram_addr_d = bus.iv_cfg_addr;
          wait_cnt_d = '0;
        end
      end

      LOOK_S: begin
        // Hold the port until the last issued lookup read has returned its data.
        if (bus.i_lookup_rd) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = IDLE_S;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end

      CFG_WR_S: begin
        ack_d   = 1'b1;
        state_d = IDLE_S;
      end

      CFG_RD_S: begin
        if (wait_cnt_q == WAIT_LAST) begin
          cfg_rdata_d = bus.iv_ram_rdata;
          ack_d       = 1'b1;
          state_d     = IDLE_S;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end

      default: begin
        state_d = INIT_S;
      end
    endcase

    ready_d = ((state_d == IDLE_S) || (state_d == LOOK_S)) && !clr_pend_d && !cfg_req;
  end

  assign bus.ov_lookup_rdata = bus.iv_ram_rdata;
  assign bus.o_lookup_ready  = ready_q;
  assign bus.o_cfg_ack       = ack_q;
  assign bus.ov_cfg_rdata    = cfg_rdata_q;
  assign bus.o_init_done     = init_done_q;
  assign bus.o_ram_wr        = ram_wr_q;
  assign bus.o_ram_rd        = lookup_grant ? bus.i_lookup_rd : ram_rd_q;
  assign bus.ov_ram_addr     = lookup_grant ? bus.iv_lookup_raddr : ram_addr_q;
  assign bus.ov_ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_inversemapping_table_access_ctrl.sv
// tb/tb_inversemapping_table_access_ctrl.sv - directed bench with a 2-cycle-latency table RAM model
module tb_inversemapping_table_access_ctrl;
  import inversemapping_table_access_ctrl_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  inversemapping_table_access_ctrl_if bus_if ();

  inversemapping_table_access_ctrl dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus_if)
  );

  always #5 i_clk = ~i_clk;

  entry_t mem [TABLE_DEPTH];
  entry_t rd_s1 = '0;
  entry_t rd_s2 = '0;

  always_ff @(posedge i_clk) begin
    if (bus_if.o_ram_wr) mem[bus_if.ov_ram_addr] <= bus_if.ov_ram_wdata;
    rd_s1 <= bus_if.o_ram_rd ? mem[bus_if.ov_ram_addr] : '0;
    rd_s2 <= rd_s1;
  end
  assign bus_if.iv_ram_rdata = rd_s2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_init_done"}, bus_if.o_init_done, 1'b0);
    chk({tag, "_ready"}, bus_if.o_lookup_ready, 1'b0);
    chk({tag, "_ack"}, bus_if.o_cfg_ack, 1'b0);
    chk({tag, "_cfg_rdata"}, bus_if.ov_cfg_rdata, 62'd0);
    chk({tag, "_ram_wr"}, bus_if.o_ram_wr, 1'b0);
    chk({tag, "_ram_rd"}, bus_if.o_ram_rd, 1'b0);
    chk({tag, "_ram_addr"}, bus_if.ov_ram_addr, 8'd0);
    chk({tag, "_ram_wdata"}, bus_if.ov_ram_wdata, 62'd0);
  endtask

  // Inputs change 1 ns after the rising edge; checks run 2 ns later, well before the falling edge.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  entry_t ent_a;
  entry_t ent_c;

  initial begin
    ent_a = make_entry(14'h0005, 48'h0011_2233_4455);
    ent_c = make_entry(14'h2A5A, 48'hDEAD_BEEF_0123);
    bus_if.i_lookup_rd     = 1'b0;
    bus_if.iv_lookup_raddr = '0;
    bus_if.i_cfg_wr        = 1'b0;
    bus_if.i_cfg_rd        = 1'b0;
    bus_if.iv_cfg_addr     = '0;
    bus_if.iv_cfg_wdata    = '0;
    bus_if.i_table_clear   = 1'b0;

    repeat (3) cyc();
    #2;
    chk_reset_outputs("rst");

    // Zero-fill after reset release
    cyc(); i_rst = 1'b0; #2;
    chk("init_gap_wr", bus_if.o_ram_wr, 1'b0);
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      cyc(); #2;
      chk("init_seq", {bus_if.o_ram_wr, bus_if.o_ram_rd, bus_if.ov_ram_addr, bus_if.ov_ram_wdata,
                       bus_if.o_init_done, bus_if.o_lookup_ready},
                      {1'b1, 1'b0, 8'(i), 62'd0, 1'b0, 1'b0});
    end
    cyc(); #2;
    chk("init_done", {bus_if.o_init_done, bus_if.o_lookup_ready, bus_if.o_ram_wr}, 3'b110);

    // Config write of entry A at 0x00
    cyc();
    bus_if.i_cfg_wr = 1'b1; bus_if.iv_cfg_addr = 8'h00; bus_if.iv_cfg_wdata = ent_a;
    #2;
    chk("cw0_ram_wr", bus_if.o_ram_wr, 1'b0);
    cyc(); #2;
    chk("cw1_ram", {bus_if.o_ram_wr, bus_if.o_ram_rd, bus_if.ov_ram_addr, bus_if.ov_ram_wdata},
                   {1'b1, 1'b0, 8'h00, ent_a});
    chk("cw1_ack", bus_if.o_cfg_ack, 1'b0);
    chk("cw1_ready", bus_if.o_lookup_ready, 1'b0);
    cyc(); #2;
    chk("cw2_ack", bus_if.o_cfg_ack, 1'b1);
    chk("cw2_ram_wr", bus_if.o_ram_wr, 1'b0);

    // Config read of 0x00, requested in the cycle after the write ack
    cyc();
    bus_if.i_cfg_wr = 1'b0; bus_if.i_cfg_rd = 1'b1; bus_if.iv_cfg_addr = 8'h00;
    #2;
    chk("cr0_idle", {bus_if.o_cfg_ack, bus_if.o_ram_wr, bus_if.o_ram_rd}, 3'b000);
    chk("cr0_ready", bus_if.o_lookup_ready, 1'b1);
    cyc(); #2;
    chk("cr1_ram", {bus_if.o_ram_rd, bus_if.o_ram_wr, bus_if.ov_ram_addr}, {1'b1, 1'b0, 8'h00});
    chk("cr1_ready", bus_if.o_lookup_ready, 1'b0);
    cyc(); #2;
    chk("cr2", {bus_if.o_ram_rd, bus_if.o_cfg_ack}, 2'b00);
    cyc(); #2;
    chk("cr3_ack", bus_if.o_cfg_ack, 1'b0);
    cyc(); #2;
    chk("cr4_ack", bus_if.o_cfg_ack, 1'b1);
    chk("cr4_rdata", bus_if.ov_cfg_rdata, ent_a);
    cyc(); bus_if.i_cfg_rd = 1'b0; #2;
    chk("cr5_ack", bus_if.o_cfg_ack, 1'b0);

    // Lookup 0,1,2 back to back, config read of 0x01 raised in the same cycle
    cyc();
    bus_if.i_lookup_rd = 1'b1; bus_if.iv_lookup_raddr = 8'h00;
    bus_if.i_cfg_rd = 1'b1; bus_if.iv_cfg_addr = 8'h01;
    #2;
    chk("lk0_ready", bus_if.o_lookup_ready, 1'b1);
    chk("lk0_ram", {bus_if.o_ram_rd, bus_if.o_ram_wr, bus_if.ov_ram_addr}, {1'b1, 1'b0, 8'h00});
    cyc(); bus_if.iv_lookup_raddr = 8'h01; #2;
    chk("lk1_ram", {bus_if.o_ram_rd, bus_if.ov_ram_addr}, {1'b1, 8'h01});
    chk("lk1_ready", bus_if.o_lookup_ready, 1'b0);
    cyc(); bus_if.iv_lookup_raddr = 8'h02; #2;
    chk("lk2_ram", {bus_if.o_ram_rd, bus_if.ov_ram_addr}, {1'b1, 8'h02});
    chk("lk2_rdata", bus_if.ov_lookup_rdata, ent_a);
    cyc(); bus_if.i_lookup_rd = 1'b0; #2;
    chk("lk3_ram_rd", bus_if.o_ram_rd, 1'b0);
    chk("lk3_rdata", bus_if.ov_lookup_rdata, 62'd0);
    chk("lk3_ready", bus_if.o_lookup_ready, 1'b0);
    cyc(); #2;
    chk("lk4_drain", {bus_if.o_ram_rd, bus_if.o_ram_wr}, 2'b00);
    cyc(); #2;
    chk("lk5_drain", {bus_if.o_ram_rd, bus_if.o_ram_wr}, 2'b00);
    cyc(); #2;
    chk("lk6_idle", {bus_if.o_ram_rd, bus_if.o_ram_wr, bus_if.o_cfg_ack}, 3'b000);
    cyc(); #2;
    chk("lk7_cfg_rd", {bus_if.o_ram_rd, bus_if.o_ram_wr, bus_if.ov_ram_addr}, {1'b1, 1'b0, 8'h01});
    cyc(); cyc(); #2;
    chk("lk9_ack", bus_if.o_cfg_ack, 1'b0);
    cyc(); #2;
    chk("lk10_ack", bus_if.o_cfg_ack, 1'b1);
    chk("lk10_rdata", bus_if.ov_cfg_rdata, 62'd0);
    cyc(); bus_if.i_cfg_rd = 1'b0; #2;
    chk("lk11_ready", {bus_if.o_lookup_ready, bus_if.o_cfg_ack}, 2'b10);

    // Clear pulsed during a lookup while a config write is held
    cyc(); bus_if.i_lookup_rd = 1'b1; bus_if.iv_lookup_raddr = 8'h03; #2;
    chk("cl0_ram", {bus_if.o_ram_rd, bus_if.ov_ram_addr}, {1'b1, 8'h03});
    cyc(); bus_if.iv_lookup_raddr = 8'h04; bus_if.i_table_clear = 1'b1; #2;
    chk("cl1_ram", {bus_if.o_ram_rd, bus_if.ov_ram_addr}, {1'b1, 8'h04});
    cyc();
    bus_if.i_table_clear = 1'b0; bus_if.i_lookup_rd = 1'b0;
    bus_if.i_cfg_wr = 1'b1; bus_if.iv_cfg_addr = 8'h10; bus_if.iv_cfg_wdata = ent_c;
    #2;
    chk("cl2_ready", bus_if.o_lookup_ready, 1'b0);
    chk("cl2_ram", {bus_if.o_ram_rd, bus_if.o_ram_wr}, 2'b00);
    cyc(); #2;
    chk("cl3_drain", {bus_if.o_ram_rd, bus_if.o_ram_wr, bus_if.o_init_done}, 3'b001);
    cyc(); #2;
    chk("cl4_drain", {bus_if.o_ram_rd, bus_if.o_ram_wr, bus_if.o_init_done}, 3'b001);
    cyc(); #2;
    chk("cl5_idle", {bus_if.o_ram_wr, bus_if.o_init_done}, 2'b01);
    cyc(); #2;
    chk("cl6_init", {bus_if.o_ram_wr, bus_if.o_init_done, bus_if.o_cfg_ack}, 3'b000);
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      cyc(); #2;
      chk("clear_seq", {bus_if.o_ram_wr, bus_if.ov_ram_addr, bus_if.ov_ram_wdata,
                        bus_if.o_cfg_ack, bus_if.o_init_done},
                       {1'b1, 8'(i), 62'd0, 1'b0, 1'b0});
    end
    cyc(); #2;
    chk("clear_done", {bus_if.o_init_done, bus_if.o_ram_wr, bus_if.o_cfg_ack, bus_if.o_lookup_ready},
                      4'b1000);
    cyc(); #2;
    chk("clear_cfg_wr", {bus_if.o_ram_wr, bus_if.ov_ram_addr, bus_if.ov_ram_wdata}, {1'b1, 8'h10, ent_c});
    cyc(); #2;
    chk("clear_cfg_ack", bus_if.o_cfg_ack, 1'b1);
    cyc(); bus_if.i_cfg_wr = 1'b0; #2;

    // Reset in the middle of a config read
    cyc(); bus_if.i_cfg_rd = 1'b1; bus_if.iv_cfg_addr = 8'h10; #2;
    cyc(); #2;
    chk("mr1_ram_rd", {bus_if.o_ram_rd, bus_if.ov_ram_addr}, {1'b1, 8'h10});
    cyc(); i_rst = 1'b1; #2;
    chk_reset_outputs("mid_rst");
    cyc(); #2;
    chk("mid_rst_ack", bus_if.o_cfg_ack, 1'b0);
    cyc(); i_rst = 1'b0; bus_if.i_cfg_rd = 1'b0; #2;
    chk("rel_gap", {bus_if.o_ram_wr, bus_if.o_cfg_ack}, 2'b00);
    cyc(); #2;
    chk("rel_addr0", {bus_if.o_ram_wr, bus_if.ov_ram_addr, bus_if.o_cfg_ack}, {1'b1, 8'h00, 1'b0});
    cyc(); #2;
    chk("rel_addr1", {bus_if.o_ram_wr, bus_if.ov_ram_addr, bus_if.o_cfg_ack}, {1'b1, 8'h01, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
